// File: rtl/traffic_phase_sched_pkg.sv
// Shared definitions for the intersection green-phase scheduler:
// state encodings, light codes, approach indices and small helpers.
package traffic_phase_sched_pkg;

    // Controller states; the cycle is ALLRED -> GREEN -> YELLOW -> ALLRED.
    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    // Light codes, one-hot {R,Y,G}.
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    // Approach indices; the search order wraps through these.
    localparam logic [1:0] DIR_NS = 2'd0;
    localparam logic [1:0] DIR_SN = 2'd1;
    localparam logic [1:0] DIR_EW = 2'd2;
    localparam logic [1:0] DIR_WE = 2'd3;

    localparam int NUM_DIRS = 4;

    // All four lights packed together, indexed by approach.
    typedef logic [NUM_DIRS-1:0][2:0] light_vec_t;

    // All approaches red except the chosen one, which shows the given code.
    function automatic light_vec_t single_light(input logic [1:0] dir,
                                                input logic [2:0] code);
        light_vec_t v;
        v      = {NUM_DIRS{LIGHT_RED}};
        v[dir] = code;
        return v;
    endfunction

    // Green length follows the vehicle count, bounded on both sides.
    function automatic logic [3:0] clamp_green(input logic [3:0] cnt,
                                               input logic [3:0] lo,
                                               input logic [3:0] hi);
        logic [3:0] r;
        if (cnt < lo) begin
            r = lo;
        end else if (cnt > hi) begin
            r = hi;
        end else begin
            r = cnt;
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_phase_sched_rr_phase_pick.sv
// Combinational next-approach selector. Searches from the start index,
// wrapping: a starved approach wins outright, otherwise the largest count
// wins with ties going to the earliest in search order; with no traffic at
// all the start index itself is chosen.
module rr_phase_pick
    import traffic_phase_sched_pkg::*;
(
    input  logic [NUM_DIRS-1:0][3:0] counts,
    input  logic [NUM_DIRS-1:0]      starved,
    input  logic [1:0]               start,
    output logic [1:0]               sel
);

    // Walk the four approaches in round-robin order from the start index.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        logic [1:0] starved_sel;
        logic [1:0] best_sel;
        logic [3:0] best_cnt;
        idx         = start;
        found       = 1'b0;
        starved_sel = start;
        best_sel    = start;
        best_cnt    = 4'd0;
        for (int k = 0; k < NUM_DIRS; k++) begin
            idx = start + 2'(k);
            if (!found && starved[idx]) begin
                found       = 1'b1;
                starved_sel = idx;
            end
            if (counts[idx] > best_cnt) begin
                best_sel = idx;
                best_cnt = counts[idx];
            end
        end
        sel = found ? starved_sel : best_sel;
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Four-approach green-phase scheduler. One approach at a time gets a green
// whose length follows its waiting count, then fixed yellow and all-red
// clearance. Everything advances only on the 1 Hz tick enable.
module traffic_phase_sched
    import traffic_phase_sched_pkg::*;
#(
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int MAX_WAIT  = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] count_ns_4b,
    input  logic [3:0] count_sn_4b,
    input  logic [3:0] count_ew_4b,
    input  logic [3:0] count_we_4b,
    output logic [2:0] light_ns,
    output logic [2:0] light_sn,
    output logic [2:0] light_ew,
    output logic [2:0] light_we,
    output logic [1:0] phase,
    output logic [3:0] time_left
);

    localparam logic [3:0] MIN_LEN    = 4'(MIN_GREEN);
    localparam logic [3:0] MAX_LEN    = 4'(MAX_GREEN);
    localparam logic [3:0] YEL_LEN    = 4'(YELLOW_T);
    localparam logic [3:0] AR_LEN     = 4'(ALLRED_T);
    localparam logic [5:0] WAIT_LIMIT = 6'(MAX_WAIT);
    localparam logic [5:0] WAIT_SAT   = 6'd63;

    state_t                   state;
    light_vec_t               lights;
    logic [5:0]               wait_cnt [NUM_DIRS];
    logic [NUM_DIRS-1:0][3:0] counts;
    logic [NUM_DIRS-1:0]      starved;
    logic [NUM_DIRS-1:0]      serving_green;
    logic [1:0]               search_start;
    logic [1:0]               pick_sel;
    logic [3:0]               green_len;
    logic                     select_now;

    assign counts       = {count_we_4b, count_ew_4b, count_sn_4b, count_ns_4b};
    assign search_start = phase + 2'd1;
    assign green_len    = clamp_green(counts[pick_sel], MIN_LEN, MAX_LEN);
    assign select_now   = tick && (state == S_ALLRED) && (time_left == 4'd1);

    assign light_ns = lights[DIR_NS];
    assign light_sn = lights[DIR_SN];
    assign light_ew = lights[DIR_EW];
    assign light_we = lights[DIR_WE];

    // Per-approach flags derived from the current registered state.
    always_comb begin
        starved       = '0;
        serving_green = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            starved[i]       = (wait_cnt[i] >= WAIT_LIMIT);
            serving_green[i] = (state == S_GREEN) && (phase == 2'(i));
        end
    end

    rr_phase_pick u_pick (
        .counts  (counts),
        .starved (starved),
        .start   (search_start),
        .sel     (pick_sel)
    );

    // Phase sequencer: counts down each interval and moves on when it expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ALLRED;
            time_left <= AR_LEN;
            phase     <= 2'd3;
            lights    <= {NUM_DIRS{LIGHT_RED}};
        end else if (tick) begin
            if (time_left == 4'd1) begin
                case (state)
                    S_ALLRED: begin
                        state     <= S_GREEN;
                        time_left <= green_len;
                        phase     <= pick_sel;
                        lights    <= single_light(pick_sel, LIGHT_GRN);
                    end
                    S_GREEN: begin
                        state     <= S_YELLOW;
                        time_left <= YEL_LEN;
                        lights    <= single_light(phase, LIGHT_YEL);
                    end
                    S_YELLOW: begin
                        state     <= S_ALLRED;
                        time_left <= AR_LEN;
                        lights    <= {NUM_DIRS{LIGHT_RED}};
                    end
                    default: begin
                        state     <= S_ALLRED;
                        time_left <= AR_LEN;
                        lights    <= {NUM_DIRS{LIGHT_RED}};
                    end
                endcase
            end else begin
                time_left <= time_left - 4'd1;
            end
        end
    end

    // Wait counters: reset on selection, otherwise grow while traffic waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (select_now && (pick_sel == 2'(i))) begin
                    wait_cnt[i] <= '0;
                end else if (!serving_green[i] && (counts[i] != 4'd0) &&
                             (wait_cnt[i] != WAIT_SAT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Self-checking bench for traffic_phase_sched: an interval-level model of the
// schedule is compared with the DUT every cycle, plus literal spot checks.
module tb_traffic_phase_sched;

    localparam int MIN_G = 3;
    localparam int MAX_G = 15;
    localparam int YEL   = 2;
    localparam int AR    = 1;
    localparam int MAXW  = 40;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [3:0] cnt [4];
    logic [2:0] light_ns, light_sn, light_ew, light_we;
    logic [1:0] phase;
    logic [3:0] time_left;

    int tests;
    int fails;

    // Model: interval kind 0=all-red 1=green 2=yellow, ticks left, served approach
    int m_kind;
    int m_left;
    int m_phase;
    int m_wait [4];
    int m_sel;
    int m_green;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    traffic_phase_sched #(
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_T  (YEL),
        .ALLRED_T  (AR),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .count_ns_4b (cnt[0]),
        .count_sn_4b (cnt[1]),
        .count_ew_4b (cnt[2]),
        .count_we_4b (cnt[3]),
        .light_ns    (light_ns),
        .light_sn    (light_sn),
        .light_ew    (light_ew),
        .light_we    (light_we),
        .phase       (phase),
        .time_left   (time_left)
    );

    function automatic int clamp_len(input int c);
        if (c < MIN_G) return MIN_G;
        if (c > MAX_G) return MAX_G;
        return c;
    endfunction

    function automatic int model_pick(input int ph);
        int idx;
        int best;
        int best_cnt;
        for (int k = 0; k < 4; k++) begin
            idx = (ph + 1 + k) % 4;
            if (m_wait[idx] >= MAXW) return idx;
        end
        best     = (ph + 1) % 4;
        best_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            idx = (ph + 1 + k) % 4;
            if (int'(cnt[idx]) > best_cnt) begin
                best     = idx;
                best_cnt = int'(cnt[idx]);
            end
        end
        return best;
    endfunction

    function automatic logic [2:0] exp_light(input int i);
        if (m_kind == 0 || i != m_phase) return 3'b100;
        if (m_kind == 1) return 3'b001;
        return 3'b010;
    endfunction

    // Reference schedule, advanced once per tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind  = 0;
            m_left  = AR;
            m_phase = 3;
            for (int i = 0; i < 4; i++) m_wait[i] = 0;
        end else if (tick) begin
            m_green = (m_kind == 1) ? m_phase : -1;
            m_sel   = -1;
            if (m_kind == 0 && m_left == 1) m_sel = model_pick(m_phase);
            for (int i = 0; i < 4; i++) begin
                if (i == m_sel) m_wait[i] = 0;
                else if (i != m_green && cnt[i] != 0 && m_wait[i] < 63) m_wait[i] = m_wait[i] + 1;
            end
            if (m_left == 1) begin
                if (m_kind == 0) begin
                    m_kind  = 1;
                    m_phase = m_sel;
                    m_left  = clamp_len(int'(cnt[m_sel]));
                end else if (m_kind == 1) begin
                    m_kind = 2;
                    m_left = YEL;
                end else begin
                    m_kind = 0;
                    m_left = AR;
                end
            end else begin
                m_left = m_left - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic compareLoop();
        logic [2:0] lv [4];
        int nonred;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                lv[0] = light_ns; lv[1] = light_sn; lv[2] = light_ew; lv[3] = light_we;
                nonred = 0;
                for (int i = 0; i < 4; i++) begin
                    checkOutput($sformatf("light%0d", i), int'(lv[i]), int'(exp_light(i)));
                    if (lv[i] != 3'b100) nonred++;
                end
                checkOutput("phase", int'(phase), m_phase);
                checkOutput("time_left", int'(time_left), m_left);
                checkOutput("at_most_one_nonred", int'(nonred <= 1), 1);
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        tick  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_light_ns", int'(light_ns), 4);
        checkOutput("rst_light_we", int'(light_we), 4);
        checkOutput("rst_phase", int'(phase), 3);
        checkOutput("rst_time_left", int'(time_left), AR);
    endtask

    task automatic tickEdges(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int n, input int tick_pct, input bit rand_counts);
        repeat (n) begin
            @(negedge clk);
            tick = ($urandom_range(0, 99) < tick_pct);
            if (rand_counts && $urandom_range(0, 7) == 0)
                cnt[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic setCounts(input int a, input int b, input int c, input int d);
        cnt[0] = 4'(a); cnt[1] = 4'(b); cnt[2] = 4'(c); cnt[3] = 4'(d);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        tick  = 1'b0;
        setCounts(0, 0, 0, 0);
        fork
            compareLoop();
        join_none

        // Equal counts: round-robin 0,1,2,3 with 4-tick greens
        setCounts(4, 4, 4, 4);
        doReset();
        tickEdges(1);
        checkOutput("eq_first_phase", int'(phase), 0);
        checkOutput("eq_first_len", int'(time_left), 4);
        checkOutput("eq_first_green", int'(light_ns), 1);
        tickEdges(7);
        checkOutput("eq_second_phase", int'(phase), 1);
        checkOutput("eq_second_len", int'(time_left), 4);
        applyStimulus(200, 100, 1'b0);

        // Heavy ns traffic starves the others until their waits hit the limit
        setCounts(10, 2, 2, 2);
        doReset();
        tick = 1'b1;
        n = 0;
        while (light_sn != 3'b001 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("starve_first_other_edge", n, 53);
        checkOutput("starve_phase", int'(phase), 1);
        checkOutput("starve_min_len", int'(time_left), 3);
        applyStimulus(150, 100, 1'b0);

        // No traffic: plain rotation with minimum greens
        setCounts(0, 0, 0, 0);
        doReset();
        tickEdges(1);
        checkOutput("idle_len", int'(time_left), 3);
        checkOutput("idle_phase", int'(phase), 0);
        applyStimulus(300, 60, 1'b0);

        // Max clamp, and a count change mid-green leaves the countdown alone
        setCounts(15, 0, 0, 0);
        doReset();
        tickEdges(1);
        checkOutput("max_len", int'(time_left), 15);
        tickEdges(5);
        checkOutput("max_after5", int'(time_left), 10);
        cnt[0] = 4'd1;
        tickEdges(1);
        checkOutput("max_after_change", int'(time_left), 9);
        tickEdges(12);
        checkOutput("min_clamp_phase", int'(phase), 0);
        checkOutput("min_clamp_len", int'(time_left), 3);
        checkOutput("min_clamp_green", int'(light_ns), 1);

        // tick held low mid-green freezes everything
        setCounts(7, 7, 7, 7);
        doReset();
        tickEdges(3);
        checkOutput("freeze_before", int'(time_left), 5);
        tick = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("freeze_hold", int'(time_left), 5);
        checkOutput("freeze_green", int'(light_ns), 1);
        tickEdges(1);
        checkOutput("freeze_resume", int'(time_left), 4);

        // Asynchronous reset asserted in the middle of yellow
        setCounts(4, 4, 4, 4);
        doReset();
        tick = 1'b1;
        n = 0;
        while (light_ns != 3'b010 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("yellow_reached", int'(light_ns), 2);
        @(posedge clk);
        #3;
        checkOutput("still_yellow", int'(light_ns), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ns", int'(light_ns), 4);
        checkOutput("async_rst_sn", int'(light_sn), 4);
        checkOutput("async_rst_time_left", int'(time_left), 1);
        checkOutput("async_rst_phase", int'(phase), 3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tickEdges(1);
        checkOutput("post_rst_phase", int'(phase), 0);
        checkOutput("post_rst_green", int'(light_ns), 1);

        // Random counts and tick pattern against the model
        applyStimulus(1500, 70, 1'b1);
        applyStimulus(500, 100, 1'b1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
